axi_burst_master: RTL and testbench

AXI-style burst initiator that drives the write and read channels of the file-system slave model (and any slave with the same reduced AXI channel set: AW, W, AR, R; no B channel). It accepts one command at a time: a write or read, a start address and a burst length. It sequences the address and data handshakes, sources write beats from an input stream and delivers read beats to an output stream. It sits between a testbench or DMA-style controller and the AXI slave, with one burst outstanding at most.

---
 rtl/axi_burst_master.sv | 179 +++++++++++++++++
 tb/tb_axi_burst_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI-style burst initiator (AW/W/AR/R only).
// Accepts one write or read command, sequences the address handshake, then
// passes data beats between the local streams and the AXI data channels.
module axi_burst_master #(
  parameter int unsigned AXI_ADDR_BITWIDTH = 32,
  parameter int unsigned AXI_DATA_BITWIDTH = 64,
  parameter int unsigned AXI_LEN_BITWIDTH  = 4,
  parameter int unsigned AXI_STRB_BITWIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  // command
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_rw,
  input  logic [AXI_ADDR_BITWIDTH-1:0] cmd_addr,
  input  logic [AXI_LEN_BITWIDTH-1:0]  cmd_len,
  // write-data stream
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [AXI_DATA_BITWIDTH-1:0] wr_data,
  input  logic [AXI_STRB_BITWIDTH-1:0] wr_strb,
  // read-data stream
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [AXI_DATA_BITWIDTH-1:0] rd_data,
  output logic                         rd_last,
  // completion
  output logic                         done,
  output logic                         done_err,
  // AW
  output logic                         m_axi_awvalid,
  output logic [AXI_ADDR_BITWIDTH-1:0] m_axi_awaddr,
  output logic [AXI_LEN_BITWIDTH-1:0]  m_axi_awlen,
  input  logic                         m_axi_awready,
  // W
  output logic                         m_axi_wvalid,
  output logic [AXI_DATA_BITWIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_BITWIDTH-1:0] m_axi_wstrb,
  output logic                         m_axi_wlast,
  input  logic                         m_axi_wready,
  // AR
  output logic                         m_axi_arvalid,
  output logic [AXI_ADDR_BITWIDTH-1:0] m_axi_araddr,
  output logic [AXI_LEN_BITWIDTH-1:0]  m_axi_arlen,
  input  logic                         m_axi_arready,
  // R
  output logic                         m_axi_rready,
  input  logic                         m_axi_rvalid,
  input  logic [AXI_DATA_BITWIDTH-1:0] m_axi_rdata,
  input  logic                         m_axi_rlast
);

  // one extra bit so a read that overruns len+1 beats is still detectable
  localparam int unsigned CNT_W = AXI_LEN_BITWIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t                       state, state_nxt;
  logic [AXI_ADDR_BITWIDTH-1:0] addr_reg;
  logic [AXI_LEN_BITWIDTH-1:0]  len_reg;
  logic [CNT_W-1:0]             beat_cnt;
  logic [CNT_W-1:0]             cnt_inc;
  logic [CNT_W-1:0]             len_plus1;
  logic                         cmd_hs;
  logic                         w_hs;
  logic                         r_hs;
  logic                         is_wlast;

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign cnt_inc   = (&beat_cnt) ? beat_cnt : beat_cnt + CNT_W'(1);
  assign len_plus1 = CNT_W'(len_reg) + CNT_W'(1);
  assign is_wlast  = (beat_cnt == CNT_W'(len_reg));

  // state register; reset drops every valid immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and state-decoded channel controls / data pass-through
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = addr_reg;
    m_axi_awlen   = len_reg;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = addr_reg;
    m_axi_arlen   = len_reg;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_data       = '0;
    rd_last       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_rw ? RD_ADDR : WR_ADDR;
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wdata  = wr_data;
        m_axi_wstrb  = wr_strb;
        m_axi_wlast  = is_wlast;
        if (wr_valid && m_axi_wready && is_wlast) state_nxt = IDLE;
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        m_axi_rready = rd_ready;
        rd_valid     = m_axi_rvalid;
        rd_data      = m_axi_rdata;
        rd_last      = m_axi_rlast;
        if (m_axi_rvalid && rd_ready && m_axi_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command latch, beat counter and registered completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      len_reg  <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      done_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            addr_reg <= cmd_addr;
            len_reg  <= cmd_len;
            beat_cnt <= '0;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_cnt <= cnt_inc;
            if (is_wlast) done <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_cnt <= cnt_inc;
            if (m_axi_rlast) begin
              done     <= 1'b1;
              done_err <= (cnt_inc != len_plus1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master; the bench plays both the command source
// and the AXI slave, with hand-computed expectations.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        done, done_err;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [3:0]  m_axi_awlen;
  logic        m_axi_wvalid, m_axi_wlast, m_axi_wready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic        m_axi_rready, m_axi_rvalid, m_axi_rlast;
  logic [63:0] m_axi_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] wd [4];

  axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arready(m_axi_arready),
    .m_axi_rready(m_axi_rready), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;

  // return every bench-driven input to quiet
  task automatic quiet_inputs();
    cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
  endtask

  // present one command for one cycle; returns at the negedge after acceptance
  task automatic cmd_pulse(input logic rw, input logic [31:0] a, input logic [3:0] l);
    @(negedge clk);
    cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic test_reset();
    quiet_inputs();
    // busy-looking slave/streams so the gating is actually exercised
    wr_valid = 1; rd_ready = 1; m_axi_wready = 1; m_axi_rvalid = 1; m_axi_rlast = 1;
    rst = 0;
    #2 rst = 1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_arvalid, m_axi_rready, wr_ready, rd_valid} !== 7'b0) begin
      n_bad++; $display("FAIL reset_valids got %b want 0000000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_arvalid, m_axi_rready, wr_ready, rd_valid});
    end
    n_cmp++; if ({done, done_err} !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", {done, done_err}); end
    n_cmp++; if ({m_axi_awaddr, m_axi_awlen} !== 36'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", {m_axi_awaddr, m_axi_awlen}); end
    @(negedge clk);
    rst = 0;
    quiet_inputs();
  endtask

  task automatic test_write();
    m_axi_awready = 1; m_axi_wready = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_rw = 0; cmd_addr = 32'h100; cmd_len = 4'd3;
    wr_valid = 1; wr_data = wd[0]; wr_strb = 8'hFF;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 0;
    #1;
    n_cmp++; if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen} !== {1'b1, 32'h100, 4'd3}) begin
      n_bad++; $display("FAIL wr_aw got v=%b a=%h l=%0d want v=1 a=100 l=3", m_axi_awvalid, m_axi_awaddr, m_axi_awlen); end
    n_cmp++; if ({m_axi_wvalid, cmd_ready} !== 2'b00) begin n_bad++; $display("FAIL wr_gate got %b want 00", {m_axi_wvalid, cmd_ready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_data = wd[i];
      #1;
      n_cmp++;
      if ({m_axi_wvalid, m_axi_wlast, m_axi_awvalid, done, m_axi_wdata, m_axi_wstrb} !== {1'b1, (i == 3), 1'b0, 1'b0, wd[i], 8'hFF}) begin
        n_bad++; $display("FAIL wr_beat%0d got v=%b last=%b aw=%b done=%b d=%h s=%h want v=1 last=%b aw=0 done=0 d=%h s=ff",
          i, m_axi_wvalid, m_axi_wlast, m_axi_awvalid, done, m_axi_wdata, m_axi_wstrb, (i == 3), wd[i]);
      end
    end
    @(negedge clk);
    wr_valid = 0;
    #1;
    n_cmp++; if ({done, done_err, cmd_ready, m_axi_wvalid} !== 4'b1010) begin
      n_bad++; $display("FAIL wr_done got %b want 1010", {done, done_err, cmd_ready, m_axi_wvalid}); end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wr_done_pulse got %b want 0", done); end
    quiet_inputs();
  endtask

  task automatic test_read();
    m_axi_arready = 1; rd_ready = 1; m_axi_rvalid = 1; m_axi_rdata = wd[0];
    cmd_pulse(1'b1, 32'h100, 4'd3);
    #1;
    n_cmp++; if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, 32'h100, 4'd3}) begin
      n_bad++; $display("FAIL rd_ar got v=%b a=%h l=%0d want v=1 a=100 l=3", m_axi_arvalid, m_axi_araddr, m_axi_arlen); end
    n_cmp++; if ({m_axi_rready, rd_valid} !== 2'b00) begin n_bad++; $display("FAIL rd_gate got %b want 00", {m_axi_rready, rd_valid}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_axi_rdata = wd[i]; m_axi_rlast = (i == 3);
      #1;
      n_cmp++;
      if ({rd_valid, rd_last, m_axi_rready, m_axi_arvalid, rd_data} !== {1'b1, (i == 3), 1'b1, 1'b0, wd[i]}) begin
        n_bad++; $display("FAIL rd_beat%0d got v=%b last=%b rr=%b ar=%b d=%h want v=1 last=%b rr=1 ar=0 d=%h",
          i, rd_valid, rd_last, m_axi_rready, m_axi_arvalid, rd_data, (i == 3), wd[i]);
      end
    end
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #1;
    n_cmp++; if ({done, done_err, cmd_ready} !== 3'b101) begin n_bad++; $display("FAIL rd_done got %b want 101", {done, done_err, cmd_ready}); end
    quiet_inputs();
  endtask

  task automatic test_aw_stall();
    wr_valid = 1; m_axi_wready = 1; wr_strb = 8'h0F; wr_data = 64'hDEAD_BEEF_0000_0001;
    cmd_pulse(1'b0, 32'h2000, 4'd1);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if ({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_wvalid, wr_ready} !== {1'b1, 32'h2000, 4'd1, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL aw_stall%0d got v=%b a=%h l=%0d wv=%b wr=%b want v=1 a=2000 l=1 wv=0 wr=0",
          c, m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_wvalid, wr_ready);
      end
      @(negedge clk);
    end
    m_axi_awready = 1;
    @(negedge clk);
    m_axi_awready = 0;
    #1;
    n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast} !== 3'b010) begin
      n_bad++; $display("FAIL aw_stall_beat0 got %b want 010", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast}); end
    @(negedge clk); #1;
    n_cmp++; if ({m_axi_wvalid, m_axi_wlast} !== 2'b11) begin n_bad++; $display("FAIL aw_stall_beat1 got %b want 11", {m_axi_wvalid, m_axi_wlast}); end
    @(negedge clk);
    wr_valid = 0;
    #1;
    n_cmp++; if ({done, done_err} !== 2'b10) begin n_bad++; $display("FAIL aw_stall_done got %b want 10", {done, done_err}); end
    quiet_inputs();
  endtask

  task automatic test_gaps();
    int k;
    logic v, r;
    // write with wr_valid and wready gaps
    m_axi_awready = 1;
    cmd_pulse(1'b0, 32'h600, 4'd3);
    @(negedge clk);
    m_axi_awready = 0;
    k = 0;
    for (int c = 0; c < 24 && k < 4; c++) begin
      v = (c % 3 != 1); r = (c % 4 != 2);
      wr_valid = v; m_axi_wready = r; wr_data = wd[k]; wr_strb = 8'hAA;
      #1;
      n_cmp++;
      if ({m_axi_wvalid, wr_ready, m_axi_wlast, m_axi_wdata} !== {v, r, (k == 3), wd[k]}) begin
        n_bad++; $display("FAIL wgap_c%0d got v=%b r=%b last=%b d=%h want v=%b r=%b last=%b d=%h",
          c, m_axi_wvalid, wr_ready, m_axi_wlast, m_axi_wdata, v, r, (k == 3), wd[k]);
      end
      @(posedge clk);
      if (v && r) k++;
      @(negedge clk);
    end
    wr_valid = 0; m_axi_wready = 0;
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL wgap_timeout got %0d beats want 4", k); end
    #1;
    n_cmp++; if ({done, done_err} !== 2'b10) begin n_bad++; $display("FAIL wgap_done got %b want 10", {done, done_err}); end
    quiet_inputs();
    // read with rd_ready toggling 1,0,1,0
    m_axi_arready = 1;
    cmd_pulse(1'b1, 32'h600, 4'd3);
    @(negedge clk);
    m_axi_arready = 0;
    k = 0;
    for (int c = 0; c < 24 && k < 4; c++) begin
      r = (c % 2 == 0);
      rd_ready = r; m_axi_rvalid = 1; m_axi_rdata = wd[k]; m_axi_rlast = (k == 3);
      #1;
      n_cmp++;
      if ({m_axi_rready, rd_valid, rd_last, rd_data, done} !== {r, 1'b1, (k == 3), wd[k], 1'b0}) begin
        n_bad++; $display("FAIL rgap_c%0d got rr=%b v=%b last=%b d=%h done=%b want rr=%b v=1 last=%b d=%h done=0",
          c, m_axi_rready, rd_valid, rd_last, rd_data, done, r, (k == 3), wd[k]);
      end
      @(posedge clk);
      if (r) k++;
      @(negedge clk);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0;
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL rgap_timeout got %0d beats want 4", k); end
    #1;
    n_cmp++; if ({done, done_err} !== 2'b10) begin n_bad++; $display("FAIL rgap_done got %b want 10", {done, done_err}); end
    quiet_inputs();
  endtask

  task automatic test_rlast_early();
    m_axi_arready = 1; rd_ready = 1;
    cmd_pulse(1'b1, 32'h100, 4'd3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rdata = wd[i]; m_axi_rlast = (i == 1);
    end
    @(negedge clk);
    // slave keeps rvalid up: a DUT back in IDLE must not pass it through
    #1;
    n_cmp++; if ({done, done_err, cmd_ready, rd_valid, m_axi_rready} !== 5'b11100) begin
      n_bad++; $display("FAIL rlast_early got %b want 11100", {done, done_err, cmd_ready, rd_valid, m_axi_rready}); end
    @(negedge clk); #1;
    n_cmp++; if ({done, done_err} !== 2'b00) begin n_bad++; $display("FAIL rlast_early_pulse got %b want 00", {done, done_err}); end
    quiet_inputs();
  endtask

  task automatic test_back_to_back();
    m_axi_awready = 1; m_axi_wready = 1; wr_valid = 1; wr_data = 64'h0123_4567_89AB_CDEF; wr_strb = 8'h01;
    cmd_pulse(1'b0, 32'h300, 4'd0);
    @(negedge clk); #1;
    n_cmp++; if ({m_axi_wvalid, m_axi_wlast} !== 2'b11) begin n_bad++; $display("FAIL len0_wlast got %b want 11", {m_axi_wvalid, m_axi_wlast}); end
    @(negedge clk);
    wr_valid = 0;
    cmd_valid = 1; cmd_rw = 1; cmd_addr = 32'h300; cmd_len = 4'd0;
    #1;
    n_cmp++; if ({done, done_err, cmd_ready} !== 3'b101) begin n_bad++; $display("FAIL len0_done got %b want 101", {done, done_err, cmd_ready}); end
    @(negedge clk);
    cmd_valid = 0;
    #1;
    n_cmp++; if ({m_axi_arvalid, m_axi_araddr, m_axi_arlen} !== {1'b1, 32'h300, 4'd0}) begin
      n_bad++; $display("FAIL b2b_ar got v=%b a=%h l=%0d want v=1 a=300 l=0", m_axi_arvalid, m_axi_araddr, m_axi_arlen); end
    m_axi_arready = 1; rd_ready = 1;
    @(negedge clk);
    m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #1;
    n_cmp++; if ({done, done_err} !== 2'b10) begin n_bad++; $display("FAIL b2b_rd_done got %b want 10", {done, done_err}); end
    quiet_inputs();
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    m_axi_awready = 1; m_axi_wready = 1; wr_valid = 1; wr_strb = 8'hFF;
    cmd_pulse(1'b0, 32'h400, 4'd7);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr_data = wd[i];
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({m_axi_wvalid, m_axi_wlast} !== 2'b10) begin n_bad++; $display("FAIL rstmid_pre got %b want 10", {m_axi_wvalid, m_axi_wlast}); end
    rst = 1;
    #1;
    n_cmp++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, wr_ready, m_axi_arvalid, m_axi_rready, cmd_ready} !== 7'b0000001) begin
      n_bad++; $display("FAIL rstmid_async got %b want 0000001",
        {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, wr_ready, m_axi_arvalid, m_axi_rready, cmd_ready});
    end
    @(negedge clk);
    rst = 0;
    quiet_inputs();
    seen_done = 0;
    for (int c = 0; c < 3; c++) begin
      #1; if (done) seen_done = 1;
      @(negedge clk);
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done got %b want 0", seen_done); end
    cmd_pulse(1'b1, 32'h500, 4'd0);
    #1;
    n_cmp++; if ({m_axi_arvalid, m_axi_araddr} !== {1'b1, 32'h500}) begin
      n_bad++; $display("FAIL rstmid_next got v=%b a=%h want v=1 a=500", m_axi_arvalid, m_axi_araddr); end
    m_axi_arready = 1; rd_ready = 1;
    @(negedge clk);
    m_axi_arready = 0; m_axi_rvalid = 1; m_axi_rlast = 1; m_axi_rdata = 64'h5;
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0;
    #1;
    n_cmp++; if ({done, done_err, cmd_ready} !== 3'b101) begin n_bad++; $display("FAIL rstmid_next_done got %b want 101", {done, done_err, cmd_ready}); end
    quiet_inputs();
  endtask

  initial begin
    wd[0] = 64'h1111_2222_3333_0000;
    wd[1] = 64'h4444_5555_6666_0001;
    wd[2] = 64'h7777_8888_9999_0002;
    wd[3] = 64'hAAAA_BBBB_CCCC_0003;
    quiet_inputs();
    test_reset();
    test_write();
    test_read();
    test_aw_stall();
    test_gaps();
    test_rlast_early();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
